// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: register map, field layout, limits and load-FSM state type for clock_ctrl
package clock_ctrl_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DIV    = 8'h04;
  localparam logic [7:0] OFF_SET    = 8'h08;
  localparam logic [7:0] OFF_TIME   = 8'h0C;
  localparam logic [7:0] OFF_ALARM  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_HIT      = 1;
  localparam int ST_ERR      = 2;
  localparam int SEC_LSB     = 0;
  localparam int MIN_LSB     = 8;
  localparam int HR_LSB      = 16;
  localparam int FIELD_W     = 6;
  localparam int ALARM_ARM   = 31;
  localparam logic [31:0] ALARM_MASK = 32'h803F_3F3F;
  localparam logic [5:0] MAX_HOURS  = 6'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;
  typedef enum logic {IDLE, LOAD} state_t;
  function automatic logic [31:0] pack_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    pack_time = '0;
    pack_time[HR_LSB +: FIELD_W]  = h;
    pack_time[MIN_LSB +: FIELD_W] = m;
    pack_time[SEC_LSB +: FIELD_W] = s;
  endfunction
endpackage

// File: rtl/clock_ctrl_prescaler.sv
// clock_ctrl_prescaler: DIV+1 cycle counter producing a registered one-cycle tick; ports en/hold/clr/div in, tick_o/count out
module clock_ctrl_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        hold,
  input  logic        clr,
  input  logic [31:0] div,
  output logic        tick_o,
  output logic [31:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count  <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= en & ~hold & ~clr & (count == div);
      count  <= (hold | clr) ? '0 : en ? ((count == div) ? '0 : count + 32'd1) : count;
    end
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: Wishbone sequencer for the timekeeper (prescaled tick, valid/ready time load, alarm irq); alarm built only with CLOCK_CTRL_ALARM_EN
import clock_ctrl_pkg::*;
module clock_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] DIV_RESET = 32'd9_999_999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        tick_o,
  output logic        set_valid_o,
  input  logic        set_ready_i,
  output logic [5:0]  set_hours_o,
  output logic [5:0]  set_minutes_o,
  output logic [5:0]  set_seconds_o,
  input  logic [5:0]  cur_hours_i,
  input  logic [5:0]  cur_minutes_i,
  input  logic [5:0]  cur_seconds_i,
  output logic        irq_o
);
  logic [1:0] ctrl;
  logic [31:0] div, count, alarm, rdata, cur_time;
  logic alarm_hit, err, req, wr, set_wr, set_go, st_wr, unused;
  logic [7:0] off;
  logic [5:0] d_hr, d_min, d_sec;
  state_t state;
  // ~wbs_ack_o blocks a second ack for a request still held after its ack
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off = {wbs_adr_i[7:2], 2'b00};
  assign wr = req & wbs_we_i;
  assign d_hr = wbs_dat_i[HR_LSB +: FIELD_W];
  assign d_min = wbs_dat_i[MIN_LSB +: FIELD_W];
  assign d_sec = wbs_dat_i[SEC_LSB +: FIELD_W];
  assign set_wr = wr & (off == OFF_SET);
  assign set_go = set_wr & (state == IDLE) & (d_hr <= MAX_HOURS) & (d_min <= MAX_MINSEC) & (d_sec <= MAX_MINSEC);
  assign st_wr = wr & (off == OFF_STATUS);
  assign cur_time = pack_time(cur_hours_i, cur_minutes_i, cur_seconds_i);
  assign unused = ^{wbs_sel_i, wbs_adr_i[1:0]};
  assign rdata = (off == OFF_CTRL)   ? {30'd0, ctrl} :
                 (off == OFF_DIV)    ? div :
                 (off == OFF_TIME)   ? cur_time :
                 (off == OFF_ALARM)  ? alarm :
                 (off == OFF_STATUS) ? {29'd0, err, alarm_hit, state == LOAD} : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl      <= '0;
      div       <= DIV_RESET;
      err       <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
      if (wr && off == OFF_CTRL) ctrl <= wbs_dat_i[1:0];
      if (wr && off == OFF_DIV) div <= wbs_dat_i;
      err <= (set_wr & ~set_go) | (err & ~(st_wr & wbs_dat_i[ST_ERR]));
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      set_valid_o   <= 1'b0;
      set_hours_o   <= '0;
      set_minutes_o <= '0;
      set_seconds_o <= '0;
    end else if (state == IDLE) begin
      if (set_go) begin
        state         <= LOAD;
        set_valid_o   <= 1'b1;
        set_hours_o   <= d_hr;
        set_minutes_o <= d_min;
        set_seconds_o <= d_sec;
      end
    end else if (set_ready_i) begin
      state       <= IDLE;
      set_valid_o <= 1'b0;
    end
  // shrinking DIV below the running count would otherwise run the count up to wrap-around
  clock_ctrl_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl[CTRL_RUN] & (state == IDLE)),
    .hold   (state == LOAD),
    .clr    (wr & (off == OFF_DIV) & (wbs_dat_i < count)),
    .div    (div),
    .tick_o (tick_o),
    .count  (count)
  );
`ifdef CLOCK_CTRL_ALARM_EN
  logic match_c, match_q;
  assign match_c = alarm[ALARM_ARM] & (alarm[30:0] == cur_time[30:0]);
  // HIT sets on the unregistered rising edge so irq_o follows the match by two cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alarm     <= '0;
      match_q   <= 1'b0;
      alarm_hit <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (wr && off == OFF_ALARM) alarm <= wbs_dat_i & ALARM_MASK;
      match_q   <= match_c;
      alarm_hit <= (match_c & ~match_q) | (alarm_hit & ~(st_wr & wbs_dat_i[ST_HIT]));
      irq_o     <= alarm_hit & ctrl[CTRL_IRQ_EN];
    end
`else
  assign alarm = '0;
  assign alarm_hit = 1'b0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: scoreboard bench for clock_ctrl covering registers, prescaler, load handshake and alarm
module tb_clock_ctrl;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = B, A_DIV = B + 32'h4, A_SET = B + 32'h8, A_TIME = B + 32'hC;
  localparam logic [31:0] A_AL = B + 32'h10, A_ST = B + 32'h14;
`ifdef CLOCK_CTRL_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  logic clk = 0, reset = 1, cyc = 0, stb = 0, we = 0, set_ready = 0;
  logic [3:0] sel = 4'hF;
  logic [31:0] adr = '0, dat = '0;
  logic [5:0] ch = '0, cm = '0, cs = '0;
  logic ack, tick, set_valid, irq;
  logic [31:0] dat_o;
  logic [5:0] sh, sm, ss;
  int n_pass = 0, n_chk = 0, tick_cnt = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (tick) tick_cnt++;
  end
  clock_ctrl dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .tick_o(tick), .set_valid_o(set_valid), .set_ready_i(set_ready),
    .set_hours_o(sh), .set_minutes_o(sm), .set_seconds_o(ss),
    .cur_hours_i(ch), .cur_minutes_i(cm), .cur_seconds_i(cs), .irq_o(irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, output logic ok, output logic [31:0] r);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; ok = 0; r = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = ack;
      r = dat_o;
    end
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    logic [31:0] r;
    wb(1'b1, a, d, ok, r);
    check("wr_ack", {31'd0, ok}, 32'd1);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic ok;
    logic [31:0] r;
    exp_q.push_back(e);
    wb(1'b0, a, '0, ok, r);
    check({tag, "_ack"}, {31'd0, ok}, 32'd1);
    check(tag, r, exp_q.pop_front());
  endtask
  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < 40);
  endtask
  initial begin : main
    logic ok;
    logic [31:0] r;
    int k, n, c0;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_valid", {31'd0, set_valid}, 0);
    check("rst_tick", {31'd0, tick}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_fields", {14'd0, sh, sm, ss}, 0);
    rd("div_rst", A_DIV, 32'd9_999_999);
    rd("ctrl_rst", A_CTRL, 0);
    rd("status_rst", A_ST, 0);
    rd("alarm_rst", A_AL, 0);
    wb(1'b0, 32'h4000_0000, '0, ok, r);
    check("oow_ack", {31'd0, ok}, 0);
    cyc = 1; stb = 1; we = 0; adr = A_CTRL; n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(ack);
    end
    cyc = 0; stb = 0;
    check("held_acks", n, 2);
    wr(A_DIV, 3);
    wr(A_CTRL, 1);
    c0 = tick_cnt;
    repeat (16) @(negedge clk);
    check("ticks16", tick_cnt - c0, 4);
    wait_tick(k);
    wait_tick(k);
    check("tick_period", k, 4);
    wr(A_CTRL, 0);
    c0 = tick_cnt;
    repeat (10) @(negedge clk);
    check("frozen", tick_cnt - c0, 0);
    wr(A_CTRL, 1);
    wait_tick(k);
    check("resume", k, 3);
    c0 = tick_cnt;
    wr(A_SET, 32'h0017_3B3B);
    check("ld_valid", {31'd0, set_valid}, 1);
    check("ld_time", {14'd0, sh, sm, ss}, {14'd0, 6'd23, 6'd59, 6'd59});
    rd("ld_busy", A_ST, 1);
    repeat (4) begin
      @(negedge clk);
      check("ld_hold", {13'd0, set_valid, sh, sm, ss}, {13'd0, 1'b1, 6'd23, 6'd59, 6'd59});
    end
    set_ready = 1;
    @(negedge clk);
    check("ld_drop", {31'd0, set_valid}, 0);
    set_ready = 0;
    check("ld_noticks", tick_cnt - c0, 0);
    wait_tick(k);
    check("ld_first_tick", k, 4);
    wr(A_SET, 32'h0018_0000);
    check("err_hr_novalid", {31'd0, set_valid}, 0);
    rd("err_hr", A_ST, 4);
    wr(A_ST, 4);
    rd("err_clr", A_ST, 0);
    wr(A_SET, 32'h0000_3C00);
    check("err_min_novalid", {31'd0, set_valid}, 0);
    rd("err_min", A_ST, 4);
    wr(A_ST, 4);
    wr(A_SET, 32'h0001_0203);
    wr(A_SET, 32'h0002_0304);
    check("busy_hold", {14'd0, sh, sm, ss}, {14'd0, 6'd1, 6'd2, 6'd3});
    rd("busy_err", A_ST, 5);
    set_ready = 1;
    @(negedge clk);
    set_ready = 0;
    check("busy_done", {31'd0, set_valid}, 0);
    wr(A_ST, 4);
    rd("set_reads0", A_SET, 0);
    ch = 6'd5; cm = 6'd6; cs = 6'd7;
    rd("time", A_TIME, 32'h0005_0607);
    ch = 0; cm = 0; cs = 0;
    wr(A_AL, 32'h8000_0105);
    wr(A_CTRL, 3);
    rd("alarm_rd", A_AL, AL ? 32'h8000_0105 : 32'h0);
    cm = 6'd1; cs = 6'd5;
    @(negedge clk);
    check("irq_1", {31'd0, irq}, 0);
    @(negedge clk);
    check("irq_2", {31'd0, irq}, {31'd0, AL});
    rd("hit", A_ST, AL ? 32'd2 : 32'd0);
    wr(A_ST, 2);
    @(negedge clk);
    check("irq_fall", {31'd0, irq}, 0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(irq);
    end
    check("no_refire", n, 0);
    rd("hit_clr", A_ST, 0);
    cm = 0; cs = 0;
    wr(A_SET, 32'h0001_0101);
    check("pre_rst_valid", {31'd0, set_valid}, 1);
    reset = 1;
    #1;
    check("rst_async", {31'd0, set_valid}, 0);
    @(negedge clk);
    reset = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Wishbone-controlled sequencer for the on-chip digital timekeeper. Generates the 1 Hz advance strobe from the system clock through a programmable prescaler, loads a new time into the timekeeper through a valid/ready handshake, and raises a maskable interrupt on an alarm match. It sits between the management-SoC Wishbone slave port and the timekeeper, whose hours/minutes/seconds outputs drive the IO pads; `irq_o` feeds `user_irq`.

## Interface
- `BASE_ADDR`, 32'h3000_0000: register window base; the block decodes `adr[31:8]`.
- `DIV_RESET`, 32'd9_999_999: reset value of DIV, giving 1 Hz at 10 MHz.
- `clk`  in  1  system clock, the Wishbone clock.
- `reset`  in  1  reset, active-high. One clock; reset is asynchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone cycle, strobe and write enable.
- `wbs_sel_i`  in  4  byte selects. Ignored; all writes are full-word.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `tick_o`  out  1  one-cycle advance strobe to the timekeeper.
- `set_valid_o`  out  1  time-load request.
- `set_ready_i`  in  1  timekeeper accepts the load.
- `set_hours_o`, `set_minutes_o`, `set_seconds_o`  out  6 each  time to load.
- `cur_hours_i`, `cur_minutes_i`, `cur_seconds_i`  in  6 each  current timekeeper time.
- `irq_o`  out  1  interrupt, registered.

## Operation
**Registers.** The offset is `adr[7:2]` × 4. Time packing in SET, TIME and ALARM is: sec in [5:0], min in [13:8], hr in [21:16].
- 0x00 CTRL: RW. bit0 RUN, bit1 IRQ_EN. Reset value 0.
- 0x04 DIV: RW. A tick occurs every DIV+1 cycles. Reset value `DIV_RESET`.
- 0x08 SET: WO; reads return 0.
  - A write starts a load.
  - A write is rejected if sec>59, min>59 or hr>23, or if a load is already busy. A rejected write sets STATUS.ERR and causes no load.
- 0x0C TIME: RO. Returns the current time inputs.
- 0x10 ALARM: RW. Time packing plus bit31 ARM. Reset value 0.
- 0x14 STATUS:
  - bit0 BUSY: RO.
  - bit1 ALARM_HIT: W1C.
  - bit2 ERR: W1C.
- Other offsets inside the window: reads return 0 and are acked; writes are acked with no effect.

**Load FSM.** States are IDLE and LOAD.
- IDLE → LOAD on an accepted SET write. This cycle registers the `set_*_o` fields and asserts `set_valid_o`.
- In LOAD, `set_valid_o` and `set_*_o` are held stable until `set_ready_i` is sampled high. Then → IDLE.
- While in LOAD, `tick_o` is suppressed and the prescaler counter is held at 0.

**Prescaler.**
- The counter advances only when RUN=1 and the FSM is in IDLE.
- When count==DIV, `tick_o` pulses and the count wraps to 0.
- RUN=0 freezes the count; it is not cleared.
- A DIV write with the new value < the current count clears the count to 0.
- DIV=0 gives a tick every enabled cycle.

**Alarm.**
- `match` = ARM & (current time == ALARM fields), registered each cycle.
- ALARM_HIT sets on a rising edge of `match` only, so a held match fires once.
- `irq_o` = ALARM_HIT & IRQ_EN, registered.
- A W1C of a flag in the same cycle the flag is set: the flag stays set.

## Timing
- **Reset values:** `wbs_ack_o`, `wbs_dat_o`, `tick_o`, `set_valid_o`, `set_*_o` and `irq_o` are all 0. FSM is IDLE, count is 0.
- **Acknowledge:**
  - Ack is registered and asserts the cycle after `cyc & stb & hit` is sampled, for one cycle.
  - No ack is issued in the cycle following an ack, so a held request does not get a double ack.
  - Out-of-window addresses receive no ack.
- **Read/write timing:** read data is valid with the ack. Write side effects are visible in the ack cycle.
- **Load latency:** `set_valid_o` rises in the ack cycle of the SET write.
- **First tick after a load:** the first tick after the handshake completes arrives DIV+1 cycles after the `set_ready_i` sample.
- **IRQ latency:** `irq_o` rises 2 cycles after the time inputs first match the alarm.
- **Reset mid-load:** `set_valid_o` drops immediately (asynchronously). The load is abandoned.

## Configuration
- `CLOCK_CTRL_ALARM_EN` defined: the alarm logic is as described above.
- Undefined:
  - The ALARM register reads 0 and ignores writes.
  - ALARM_HIT is constant 0.
  - `irq_o` is tied to 0.
  - The IRQ_EN bit is still stored.

## Structure
- `clock_ctrl_pkg` holds:
  - register offsets;
  - CTRL and STATUS bit indices;
  - time-field LSB positions and width 6;
  - limits MAX_HOURS=23 and MAX_MINSEC=59;
  - the FSM state typedef.
- Sub-module `clock_ctrl_prescaler` holds the counter, the DIV compare, the clear/hold inputs and `tick_o`.

## Test plan
- Reset, then read DIV → 9_999_999. Read CTRL, STATUS and ALARM → 0. `irq_o`=0.
- Write DIV=3, CTRL=1 → `tick_o` pulses every 4 cycles. Write CTRL=0 mid-count → no ticks; the count resumes from the frozen value on re-enable.
- Write SET=0x0017_3B3B (23:59:59) with `set_ready_i` held low for 5 cycles:
  - `set_valid_o` is high 6 cycles and the fields are stable;
  - BUSY=1 and no ticks during that time;
  - the first tick arrives DIV+1 cycles after ready.
- Write SET with hr=24 → no `set_valid_o`, STATUS.ERR=1. Write STATUS=4 → ERR=0. A SET write while BUSY → ERR=1 and the held fields are unchanged.
- ALARM=0x8000_0105 (00:01:05), IRQ_EN=1, drive the time inputs to 00:01:05 for 10 cycles → ALARM_HIT sets once and `irq_o` rises 2 cycles after the match. A W1C of HIT → `irq_o` falls and does not re-fire while the match is held.
- Without `CLOCK_CTRL_ALARM_EN`, repeat the previous scenario → `irq_o` stays 0 and ALARM reads 0.
